traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_phase_ctrl_pkg.sv | 33 +++
 rtl/traffic_phase_ctrl_if.sv | 20 ++
 rtl/traffic_phase_ctrl_rr_pick.sv | 40 ++++
 rtl/traffic_phase_ctrl.sv | 161 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and helpers for the traffic phase controller:
//               FSM state encoding, group index width, GROUP_MAP field access.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GREEN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Widest GROUP_MAP the field extractor accepts (NUM_DIRS * GW bits).
    localparam int c_MAP_MAX_W = 256;

    // Bits needed to hold a group index; never narrower than one bit.
    function automatic int group_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Group number of direction idx inside a packed map of gw-bit fields.
    function automatic int group_field(input logic [c_MAP_MAX_W-1:0] map,
                                       input int idx, input int gw);
        logic [c_MAP_MAX_W-1:0] field_mask;
        field_mask = (c_MAP_MAX_W'(1) << gw) - c_MAP_MAX_W'(1);
        return int'(32'((map >> (idx * gw)) & field_mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl_if
// Description : Sensor/grant bundle between the intersection and controller.
//               slave = controller side, master = intersection side.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_phase_ctrl_if #(
    parameter int NUM_DIRS = 3,
    parameter int GW       = 1
);
    logic [NUM_DIRS-1:0] sense;
    logic [NUM_DIRS-1:0] go;
    logic [GW-1:0]       active_group;
    logic                all_red;

    modport master (output sense, input go, input active_group, input all_red);
    modport slave  (input sense, output go, output active_group, output all_red);
endinterface
`default_nettype wire

// File: rtl/traffic_phase_ctrl_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : traffic_rr_pick
// Description : Combinational round-robin picker. Returns the first pending
//               group found scanning upward from last_group+1 (mod groups).
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_rr_pick
    import traffic_pkg::*;
#(
    parameter int NUM_GROUPS = 2,
    parameter int GW         = group_width(NUM_GROUPS)
) (
    input  wire logic [NUM_GROUPS-1:0] pending,
    input  wire logic [GW-1:0]         last_group,
    output logic                       valid,
    output logic [GW-1:0]              group
);

    int w_best_dist;
    int w_dist;

    // Keep the pending group with the smallest rotational distance from last_group.
    always_comb begin
        valid       = 1'b0;
        group       = '0;
        w_best_dist = NUM_GROUPS;
        w_dist      = 0;
        for (int j = 0; j < NUM_GROUPS; j++) begin
            w_dist = (j + NUM_GROUPS - int'(last_group) - 1) % NUM_GROUPS;
            if (pending[j] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                valid       = 1'b1;
                group       = GW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl
// Description : Traffic intersection controller core. Per-direction request
//               latches, round-robin group arbitration, bounded green time
//               and an all-red clearance interval between groups.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS     = 3,
    parameter int NUM_GROUPS   = 2,
    parameter logic [NUM_DIRS*group_width(NUM_GROUPS)-1:0] GROUP_MAP = 3'b100,
    parameter int MAX_GREEN    = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    traffic_phase_ctrl_if.slave   bus
);

    localparam int c_GW  = group_width(NUM_GROUPS);
    localparam int c_GCW = group_width(MAX_GREEN + 1);
    localparam int c_CCW = group_width(CLEAR_CYCLES + 1);

    state_t              r_state,      w_state_nxt;
    logic [NUM_DIRS-1:0] r_req,        w_req_nxt;
    logic [NUM_DIRS-1:0] r_go,         w_go_nxt;
    logic                r_all_red;
    logic [c_GW-1:0]     r_cur_group,  w_cur_nxt;
    logic [c_GW-1:0]     r_last_group, w_last_nxt;
    logic [c_GCW-1:0]    r_green_cnt,  w_gcnt_nxt;
    logic [c_CCW-1:0]    r_clr_cnt,    w_ccnt_nxt;

    logic [c_GW-1:0]       w_dir_group [NUM_DIRS];
    logic [NUM_GROUPS-1:0] w_pending;
    logic [NUM_DIRS-1:0]   w_cur_mask;
    logic [NUM_DIRS-1:0]   w_pick_mask;
    logic                  w_pick_valid;
    logic [c_GW-1:0]       w_pick_group;
    logic                  w_cur_pend;
    logic                  w_other_pend;
    logic                  w_arb;

    // Static direction-to-group table unpacked from GROUP_MAP.
    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir_group
        localparam int c_GRP = group_field(c_MAP_MAX_W'(GROUP_MAP), i, c_GW);
        assign w_dir_group[i] = c_GW'(c_GRP);
    end

    // Request latches, per-group pending flags and direction masks.
    always_comb begin
        w_req_nxt   = (r_req | bus.sense) & ~(r_go & ~bus.sense);
        w_pending   = '0;
        w_cur_mask  = '0;
        w_pick_mask = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                if (w_dir_group[i] == c_GW'(g)) begin
                    w_pending[g] = w_pending[g] | r_req[i];
                end
            end
        end
        for (int i = 0; i < NUM_DIRS; i++) begin
            w_cur_mask[i]  = (w_dir_group[i] == r_cur_group);
            w_pick_mask[i] = (w_dir_group[i] == w_pick_group);
        end
        w_cur_pend   = |(w_req_nxt & w_cur_mask);
        w_other_pend = |(w_req_nxt & ~w_cur_mask);
    end

    traffic_rr_pick #(
        .NUM_GROUPS (NUM_GROUPS),
        .GW         (c_GW)
    ) u_rr_pick (
        .pending    (w_pending),
        .last_group (r_last_group),
        .valid      (w_pick_valid),
        .group      (w_pick_group)
    );

    // Next-state and next-output logic for the IDLE/GREEN/CLEAR sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_go_nxt    = '0;
        w_cur_nxt   = r_cur_group;
        w_last_nxt  = r_last_group;
        w_gcnt_nxt  = r_green_cnt;
        w_ccnt_nxt  = r_clr_cnt;
        w_arb       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb = 1'b1;
            end
            ST_GREEN: begin
                // Once the green budget is spent, any other pending group preempts.
                if (!w_cur_pend ||
                    ((r_green_cnt >= c_GCW'(MAX_GREEN - 1)) && w_other_pend)) begin
                    w_state_nxt = ST_CLEAR;
                    w_ccnt_nxt  = '0;
                end else begin
                    w_go_nxt = r_req & w_req_nxt & w_cur_mask;
                    if (r_green_cnt != c_GCW'(MAX_GREEN)) begin
                        w_gcnt_nxt = r_green_cnt + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == c_CCW'(CLEAR_CYCLES - 1)) begin
                    w_arb = 1'b1;
                end else begin
                    w_ccnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_arb) begin
            if (w_pick_valid) begin
                w_state_nxt = ST_GREEN;
                w_cur_nxt   = w_pick_group;
                w_last_nxt  = w_pick_group;
                w_gcnt_nxt  = '0;
                w_go_nxt    = r_req & w_req_nxt & w_pick_mask;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State, latches and registered outputs; reset takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_go         <= '0;
            r_all_red    <= 1'b1;
            r_cur_group  <= '0;
            r_last_group <= c_GW'(NUM_GROUPS - 1);
            r_green_cnt  <= '0;
            r_clr_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_go         <= w_go_nxt;
            r_all_red    <= (w_state_nxt != ST_GREEN);
            r_cur_group  <= w_cur_nxt;
            r_last_group <= w_last_nxt;
            r_green_cnt  <= w_gcnt_nxt;
            r_clr_cnt    <= w_ccnt_nxt;
        end
    end

    assign bus.go           = r_go;
    assign bus.all_red      = r_all_red;
    assign bus.active_group = r_cur_group;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_ctrl
// Description : Scoreboard bench for traffic_phase_ctrl with default
//               parameters (dir0,dir1 -> group 0, dir2 -> group 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

    typedef struct {
        logic [2:0] go;
        logic       all_red;
        logic       ag;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];
    exp_t mon_e;

    traffic_phase_ctrl_if #(.NUM_DIRS(3), .GW(1)) bus ();

    traffic_phase_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops the expected response for each edge and compares.
    always @(posedge clk) begin
        #1;
        if ((bus.go[1:0] != 2'b00) && bus.go[2]) begin
            n_err++;
            $display("FAIL group_exclusive: go=%b spans both groups, required single group", bus.go);
        end
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if ((bus.go !== mon_e.go) || (bus.all_red !== mon_e.all_red) ||
                (!mon_e.all_red && (bus.active_group !== mon_e.ag))) begin
                n_err++;
                $display("FAIL %s: go=%b all_red=%b group=%0d, required go=%b all_red=%b group=%0d",
                         mon_e.name, bus.go, bus.all_red, bus.active_group,
                         mon_e.go, mon_e.all_red, mon_e.ag);
            end
        end
    end

    // Drive sense for the next edge and queue the outputs expected after it.
    task automatic apply(input logic [2:0] s, input logic [2:0] g, input logic ar,
                         input logic ag, input string nm);
        exp_t e;
        @(negedge clk);
        bus.sense = s;
        e.go      = g;
        e.all_red = ar;
        e.ag      = ag;
        e.name    = nm;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_now(input string nm);
        n_vec++;
        if ((bus.go !== 3'b000) || (bus.all_red !== 1'b1) || (bus.active_group !== 1'b0)) begin
            n_err++;
            $display("FAIL %s: go=%b all_red=%b group=%0d, required go=000 all_red=1 group=0",
                     nm, bus.go, bus.all_red, bus.active_group);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sense = 3'b000;
        rst = 1'b1;
        #1;
        check_reset_now("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(3'b000, 3'b000, 1'b1, 1'b0, "post_reset_idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required natural end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.sense = 3'b000;

        // Single request: latch, grant, release, clearance, idle.
        do_reset();
        apply(3'b001, 3'b000, 1'b1, 1'b0, "single_latch");
        for (int k = 0; k < 4; k++) apply(3'b001, 3'b001, 1'b0, 1'b0, "single_green");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "single_release");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "single_clear");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "single_idle");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "single_idle2");

        // Concurrent directions of one group.
        do_reset();
        apply(3'b011, 3'b000, 1'b1, 1'b0, "conc_latch");
        apply(3'b011, 3'b011, 1'b0, 1'b0, "conc_green");
        apply(3'b011, 3'b011, 1'b0, 1'b0, "conc_green2");
        apply(3'b010, 3'b010, 1'b0, 1'b0, "conc_dir0_off");
        apply(3'b010, 3'b010, 1'b0, 1'b0, "conc_dir1_hold");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "conc_release");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "conc_clear");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "conc_idle");

        // Conflict: group 0 first, two all-red cycles, then group 1.
        do_reset();
        apply(3'b101, 3'b000, 1'b1, 1'b0, "rr_latch");
        apply(3'b101, 3'b001, 1'b0, 1'b0, "rr_g0_first");
        apply(3'b101, 3'b001, 1'b0, 1'b0, "rr_g0_hold");
        apply(3'b100, 3'b000, 1'b1, 1'b0, "rr_clear1");
        apply(3'b100, 3'b000, 1'b1, 1'b0, "rr_clear2");
        apply(3'b100, 3'b100, 1'b0, 1'b1, "rr_g1_grant");
        apply(3'b100, 3'b100, 1'b0, 1'b1, "rr_g1_hold");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "rr_release");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "rr_clear");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "rr_idle");

        // Preemption after MAX_GREEN cycles, then return to the held direction.
        do_reset();
        apply(3'b001, 3'b000, 1'b1, 1'b0, "pre_latch");
        apply(3'b001, 3'b001, 1'b0, 1'b0, "pre_g0_grant");
        for (int k = 0; k < 7; k++) apply(3'b101, 3'b001, 1'b0, 1'b0, "pre_g0_budget");
        apply(3'b101, 3'b000, 1'b1, 1'b0, "pre_preempt");
        apply(3'b101, 3'b000, 1'b1, 1'b0, "pre_clear");
        apply(3'b101, 3'b100, 1'b0, 1'b1, "pre_g1_grant");
        apply(3'b101, 3'b100, 1'b0, 1'b1, "pre_g1_hold");
        apply(3'b001, 3'b000, 1'b1, 1'b0, "pre_g1_release");
        apply(3'b001, 3'b000, 1'b1, 1'b0, "pre_clear2");
        apply(3'b001, 3'b001, 1'b0, 1'b0, "pre_g0_return");
        apply(3'b001, 3'b001, 1'b0, 1'b0, "pre_g0_hold");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "pre_release");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "pre_clear3");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "pre_idle");

        // Lone group is never preempted.
        do_reset();
        apply(3'b001, 3'b000, 1'b1, 1'b0, "alone_latch");
        for (int k = 0; k < 21; k++) apply(3'b001, 3'b001, 1'b0, 1'b0, "alone_hold");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "alone_release");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "alone_clear");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "alone_idle");

        // Asynchronous reset in the middle of GREEN with sense held.
        do_reset();
        apply(3'b001, 3'b000, 1'b1, 1'b0, "arst_latch");
        apply(3'b001, 3'b001, 1'b0, 1'b0, "arst_grant");
        apply(3'b001, 3'b001, 1'b0, 1'b0, "arst_green");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_now("arst_immediate");
        #1;
        rst = 1'b0;
        apply(3'b001, 3'b000, 1'b1, 1'b0, "arst_relatch");
        apply(3'b001, 3'b001, 1'b0, 1'b0, "arst_regrant");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "arst_release");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "arst_clear");
        apply(3'b000, 3'b000, 1'b1, 1'b0, "arst_idle");

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
